// File: rtl/pll_lock_sequencer.sv
// PLL bring-up sequencer: pulses PLL reset, waits for a qualified lock and releases the
// downstream domain; retries timed-out lock attempts and parks in FAIL until retry_req.
//
// state     | meaning
// ----------+-----------------------------------------------------------------
// RESET_PLL | pll_rst held high for PLL_RST_CYCLES
// WAIT_LOCK | PLL running, waiting for lock_s with timeout
// STABLE    | lock_s seen, counting LOCK_STABLE_CYCLES consecutive lock cycles
// RUN       | downstream released, watching for lock loss
// FAIL      | retries exhausted, PLL held in reset until retry_req
module pll_lock_sequencer #(
    parameter int PLL_RST_CYCLES      = 16,
    parameter int LOCK_TIMEOUT_CYCLES = 50000,
    parameter int LOCK_STABLE_CYCLES  = 1000,
    parameter int MAX_RETRIES         = 3
) (
    input  logic       clkin,
    input  logic       rst,
    input  logic       pll_lock,
    input  logic       retry_req,
    output logic       pll_rst,
    output logic       sys_rst,
    output logic       ready,
    output logic       fail,
    output logic [1:0] retry_cnt,
    output logic [7:0] lock_loss_cnt
);

    localparam int MAX_AB  = (PLL_RST_CYCLES > LOCK_TIMEOUT_CYCLES) ? PLL_RST_CYCLES : LOCK_TIMEOUT_CYCLES;
    localparam int MAX_CYC = (MAX_AB > LOCK_STABLE_CYCLES) ? MAX_AB : LOCK_STABLE_CYCLES;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [1:0]       RETRY_MAX    = 2'(MAX_RETRIES);

    typedef enum logic [2:0] {
        RESET_PLL,
        WAIT_LOCK,
        STABLE,
        RUN,
        FAIL
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             lock_meta;
    logic             lock_s;

    // pll_lock comes from the PLL's own domain; two flops before the FSM looks at it
    always_ff @(posedge clkin) begin
        if (rst) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
        end else begin
            lock_meta <= pll_lock;
            lock_s    <= lock_meta;
        end
    end

    always_ff @(posedge clkin) begin
        if (rst) begin
            state         <= RESET_PLL;
            cnt           <= '0;
            pll_rst       <= 1'b1;
            sys_rst       <= 1'b1;
            ready         <= 1'b0;
            fail          <= 1'b0;
            retry_cnt     <= 2'd0;
            lock_loss_cnt <= 8'd0;
        end else begin
            case (state)
                RESET_PLL: begin
                    if (cnt == RST_LAST) begin
                        state   <= WAIT_LOCK;
                        cnt     <= '0;
                        pll_rst <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                WAIT_LOCK: begin
                    if (lock_s) begin
                        state <= STABLE;
                        cnt   <= '0;
                    end else if (cnt == TIMEOUT_LAST) begin
                        cnt     <= '0;
                        pll_rst <= 1'b1;
                        if (retry_cnt == RETRY_MAX) begin
                            state <= FAIL;
                            fail  <= 1'b1;
                        end else begin
                            state     <= RESET_PLL;
                            retry_cnt <= retry_cnt + 2'd1;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                STABLE: begin
                    if (!lock_s) begin
                        state <= WAIT_LOCK;
                        cnt   <= '0;
                    end else if (cnt == STABLE_LAST) begin
                        state   <= RUN;
                        cnt     <= '0;
                        sys_rst <= 1'b0;
                        ready   <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                RUN: begin
                    if (!lock_s) begin
                        state     <= RESET_PLL;
                        cnt       <= '0;
                        pll_rst   <= 1'b1;
                        sys_rst   <= 1'b1;
                        ready     <= 1'b0;
                        retry_cnt <= 2'd0;
                        if (lock_loss_cnt != 8'hFF) lock_loss_cnt <= lock_loss_cnt + 8'd1;
                    end
                end
                FAIL: begin
                    if (retry_req) begin
                        state     <= RESET_PLL;
                        cnt       <= '0;
                        fail      <= 1'b0;
                        retry_cnt <= 2'd0;
                    end
                end
                default: begin
                    state   <= RESET_PLL;
                    cnt     <= '0;
                    pll_rst <= 1'b1;
                    sys_rst <= 1'b1;
                    ready   <= 1'b0;
                    fail    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Bench for pll_lock_sequencer: directed vector table, lock-loss saturation run and a
// randomized run against a phase/elapsed-time reference model.
module tb_pll_lock_sequencer;

    localparam int RST_N     = 4;
    localparam int TIMEOUT_N = 32;
    localparam int STABLE_N  = 8;
    localparam int RETRIES_N = 2;

    logic       clkin;
    logic       rst;
    logic       pll_lock;
    logic       retry_req;
    logic       pll_rst;
    logic       sys_rst;
    logic       ready;
    logic       fail;
    logic [1:0] retry_cnt;
    logic [7:0] lock_loss_cnt;

    int checks = 0;
    int errors = 0;

    pll_lock_sequencer #(
        .PLL_RST_CYCLES     (RST_N),
        .LOCK_TIMEOUT_CYCLES(TIMEOUT_N),
        .LOCK_STABLE_CYCLES (STABLE_N),
        .MAX_RETRIES        (RETRIES_N)
    ) dut (
        .clkin        (clkin),
        .rst          (rst),
        .pll_lock     (pll_lock),
        .retry_req    (retry_req),
        .pll_rst      (pll_rst),
        .sys_rst      (sys_rst),
        .ready        (ready),
        .fail         (fail),
        .retry_cnt    (retry_cnt),
        .lock_loss_cnt(lock_loss_cnt)
    );

    initial begin
        clkin = 1'b0;
        forever #5 clkin = ~clkin;
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    typedef struct {
        int         n;
        logic       rst;
        logic       lock;
        logic       rr;
        logic       e_pll;
        logic       e_sys;
        logic       e_rdy;
        logic       e_fail;
        logic [1:0] e_rc;
        logic [7:0] e_ll;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input int n, input logic r, input logic l, input logic q,
                       input logic ep, input logic es, input logic er, input logic ef,
                       input logic [1:0] rc, input logic [7:0] ll);
        vec_t v;
        v.n = n; v.rst = r; v.lock = l; v.rr = q;
        v.e_pll = ep; v.e_sys = es; v.e_rdy = er; v.e_fail = ef; v.e_rc = rc; v.e_ll = ll;
        vecs.push_back(v);
    endtask

    task automatic wait_ready(input logic want, input int bound, input string name);
        int n = 0;
        while (ready !== want && n < bound) begin
            @(negedge clkin);
            n++;
        end
        check(name, 8'(ready), 8'(want));
    endtask

    // Reference model: phase plus cycles elapsed in it; lock seen two edges late
    localparam int P_PLLRESET = 10;
    localparam int P_WAIT     = 11;
    localparam int P_QUAL     = 12;
    localparam int P_RUN      = 13;
    localparam int P_DEAD     = 14;

    int ph;
    int elapsed;
    int m_retry;
    int m_loss;
    bit lock_pipe[$];

    function automatic void model_step(input bit r, input bit l, input bit q);
        bit seen;
        if (r) begin
            ph = P_PLLRESET; elapsed = 0; m_retry = 0; m_loss = 0;
            lock_pipe = '{1'b0, 1'b0};
            return;
        end
        seen = lock_pipe.pop_front();
        lock_pipe.push_back(l);
        case (ph)
            P_PLLRESET: begin
                elapsed++;
                if (elapsed == RST_N) begin ph = P_WAIT; elapsed = 0; end
            end
            P_WAIT: begin
                if (seen) begin
                    ph = P_QUAL; elapsed = 0;
                end else begin
                    elapsed++;
                    if (elapsed == TIMEOUT_N) begin
                        elapsed = 0;
                        if (m_retry >= RETRIES_N) ph = P_DEAD;
                        else begin m_retry++; ph = P_PLLRESET; end
                    end
                end
            end
            P_QUAL: begin
                if (!seen) begin
                    ph = P_WAIT; elapsed = 0;
                end else begin
                    elapsed++;
                    if (elapsed == STABLE_N) begin ph = P_RUN; elapsed = 0; end
                end
            end
            P_RUN: begin
                if (!seen) begin
                    m_loss = (m_loss + 1 > 255) ? 255 : m_loss + 1;
                    m_retry = 0; ph = P_PLLRESET; elapsed = 0;
                end
            end
            default: begin
                if (q) begin m_retry = 0; ph = P_PLLRESET; elapsed = 0; end
            end
        endcase
    endfunction

    initial begin
        int lvl;
        int run_left;

        rst = 1'b1; pll_lock = 1'b0; retry_req = 1'b0;

        //   n   rst lock rr   pll sys rdy fail rc  ll
        add(2,   1,  0,   0,   1,  1,  0,  0,   0,  0);   // reset
        add(3,   0,  0,   0,   1,  1,  0,  0,   0,  0);
        add(1,   0,  0,   0,   0,  1,  0,  0,   0,  0);   // pll_rst released after 4 cycles
        add(5,   0,  0,   0,   0,  1,  0,  0,   0,  0);
        add(10,  0,  1,   1,   0,  1,  0,  0,   0,  0);   // lock at edge k, retry_req ignored
        add(1,   0,  1,   0,   0,  0,  1,  0,   0,  0);   // RUN at k+10
        add(1,   0,  1,   1,   0,  0,  1,  0,   0,  0);   // retry_req in RUN ignored
        add(1,   0,  0,   0,   0,  0,  1,  0,   0,  0);   // lock falls before edge m
        add(1,   0,  1,   0,   0,  0,  1,  0,   0,  0);
        add(1,   0,  1,   0,   1,  1,  0,  0,   0,  1);   // m+2: loss handled
        add(3,   0,  1,   0,   1,  1,  0,  0,   0,  1);
        add(1,   0,  1,   0,   0,  1,  0,  0,   0,  1);
        add(5,   0,  1,   0,   0,  1,  0,  0,   0,  1);   // STABLE count 4
        add(1,   0,  0,   0,   0,  1,  0,  0,   0,  1);   // one-cycle chatter
        add(10,  0,  1,   0,   0,  1,  0,  0,   0,  1);   // requalification, no early RUN
        add(1,   0,  1,   0,   0,  0,  1,  0,   0,  1);
        add(2,   0,  0,   0,   0,  0,  1,  0,   0,  1);   // lock lost for good
        add(1,   0,  0,   0,   1,  1,  0,  0,   0,  2);
        add(3,   0,  0,   0,   1,  1,  0,  0,   0,  2);
        add(1,   0,  0,   0,   0,  1,  0,  0,   0,  2);
        add(31,  0,  0,   0,   0,  1,  0,  0,   0,  2);
        add(1,   0,  0,   0,   1,  1,  0,  0,   1,  2);   // first timeout
        add(35,  0,  0,   0,   0,  1,  0,  0,   1,  2);
        add(1,   0,  0,   0,   1,  1,  0,  0,   2,  2);   // second timeout
        add(35,  0,  0,   0,   0,  1,  0,  0,   2,  2);
        add(1,   0,  0,   0,   1,  1,  0,  1,   2,  2);   // third timeout -> FAIL
        add(20,  0,  1,   0,   1,  1,  0,  1,   2,  2);   // lock ignored in FAIL
        add(1,   0,  1,   1,   1,  1,  0,  0,   0,  2);   // retry_req recovers
        add(3,   0,  1,   0,   1,  1,  0,  0,   0,  2);
        add(1,   0,  1,   0,   0,  1,  0,  0,   0,  2);
        add(8,   0,  1,   0,   0,  1,  0,  0,   0,  2);
        add(1,   0,  1,   0,   0,  0,  1,  0,   0,  2);
        add(2,   0,  1,   1,   0,  0,  1,  0,   0,  2);   // retry_req in RUN ignored
        add(1,   1,  1,   0,   1,  1,  0,  0,   0,  0);   // rst in RUN
        add(5,   1,  1,   0,   1,  1,  0,  0,   0,  0);   // held in reset
        add(3,   0,  1,   0,   1,  1,  0,  0,   0,  0);
        add(1,   0,  1,   0,   0,  1,  0,  0,   0,  0);
        add(7,   0,  1,   0,   0,  1,  0,  0,   0,  0);   // STABLE count 6
        add(1,   1,  1,   0,   1,  1,  0,  0,   0,  0);   // rst mid-qualification
        add(3,   0,  1,   0,   1,  1,  0,  0,   0,  0);
        add(1,   0,  1,   0,   0,  1,  0,  0,   0,  0);
        add(8,   0,  1,   0,   0,  1,  0,  0,   0,  0);
        add(1,   0,  1,   0,   0,  0,  1,  0,   0,  0);
        add(3,   0,  0,   0,   1,  1,  0,  0,   0,  1);
        add(108, 0,  0,   0,   1,  1,  0,  1,   2,  1);   // FAIL again
        add(1,   1,  0,   0,   1,  1,  0,  0,   0,  0);   // rst in FAIL

        foreach (vecs[i]) begin
            rst = vecs[i].rst; pll_lock = vecs[i].lock; retry_req = vecs[i].rr;
            repeat (vecs[i].n) @(posedge clkin);
            @(negedge clkin);
            check($sformatf("vec%0d pll_rst", i), 8'(pll_rst), 8'(vecs[i].e_pll));
            check($sformatf("vec%0d sys_rst", i), 8'(sys_rst), 8'(vecs[i].e_sys));
            check($sformatf("vec%0d ready", i), 8'(ready), 8'(vecs[i].e_rdy));
            check($sformatf("vec%0d fail", i), 8'(fail), 8'(vecs[i].e_fail));
            check($sformatf("vec%0d retry_cnt", i), 8'(retry_cnt), 8'(vecs[i].e_rc));
            check($sformatf("vec%0d lock_loss_cnt", i), lock_loss_cnt, vecs[i].e_ll);
        end

        // lock_loss_cnt saturation
        rst = 1'b0; pll_lock = 1'b1; retry_req = 1'b0;
        for (int i = 0; i < 258; i++) begin
            wait_ready(1'b1, 40, "sat_ready_up");
            pll_lock = 1'b0;
            wait_ready(1'b0, 10, "sat_ready_down");
            pll_lock = 1'b1;
            if (i == 253 || i == 254 || i == 257)
                check($sformatf("lock_loss_sat%0d", i), lock_loss_cnt, 8'((i + 1 > 255) ? 255 : i + 1));
        end

        // randomized run against the reference model
        lvl = 1; run_left = 0;
        for (int c = 0; c < 15000 && errors <= 20; c++) begin
            if (run_left == 0) begin
                lvl = int'($urandom_range(0, 1));
                run_left = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3))
                                                        : int'($urandom_range(5, 120));
            end
            run_left--;
            pll_lock  = lvl[0];
            retry_req = ($urandom_range(0, 15) == 0);
            rst       = (c == 0) || ($urandom_range(0, 499) == 0);
            model_step(rst, pll_lock, retry_req);
            @(posedge clkin);
            @(negedge clkin);
            check("rand pll_rst", 8'(pll_rst), 8'(ph == P_PLLRESET || ph == P_DEAD));
            check("rand sys_rst", 8'(sys_rst), 8'(ph != P_RUN));
            check("rand ready", 8'(ready), 8'(ph == P_RUN));
            check("rand fail", 8'(fail), 8'(ph == P_DEAD));
            check("rand retry_cnt", 8'(retry_cnt), 8'(m_retry));
            check("rand lock_loss_cnt", lock_loss_cnt, 8'(m_loss));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
